rip_regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the rip-cpu core, generalising the single-issue 2R/1W file. It provides NRD registered read ports with same-cycle write bypass, NWR prioritised write ports, a per-register busy scoreboard for hazard detection, and a configurable stack-pointer reset value. It sits between decode (read side, issue side) and the memory-access/writeback stages (write side).

---
 rtl/rip_regfile_mp.sv | 144 ++++++++++++++
 tb/tb_rip_regfile_mp.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rip_regfile_mp.sv
// rip_regfile_mp: multi-port integer register file for the rip-cpu core.
// NRD registered read ports with same-cycle write bypass, NWR write ports where the
// highest port index wins, and a per-register busy scoreboard for hazard detection.
// Register 0 reads as zero, ignores writes and is never busy.

module rip_regfile_mp #(
    parameter int unsigned     XLEN    = 32,
    parameter int unsigned     NREG    = 32,
    parameter int unsigned     NRD     = 2,
    parameter int unsigned     NWR     = 2,
    parameter int unsigned     SP_IDX  = 2,
    parameter logic [XLEN-1:0] SP_INIT = '0,
    localparam int unsigned    AW      = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_rd_en,
    input  logic [NRD*AW-1:0]    i_rd_addr,
    output logic [NRD*XLEN-1:0]  o_rd_data,
    output logic [NRD-1:0]       o_rd_busy,
    input  logic [NWR-1:0]       i_wr_en,
    input  logic [NWR*AW-1:0]    i_wr_addr,
    input  logic [NWR*XLEN-1:0]  i_wr_data,
    input  logic                 i_iss_valid,
    input  logic [AW-1:0]        i_iss_rd,
    input  logic                 i_flush
);

    // Architectural state
    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;

    // Registered read outputs
    logic [XLEN-1:0] r_rd_data [NRD];
    logic [NRD-1:0]  r_rd_busy;

    // Per-register view of this cycle's writes, already resolved across write ports
    logic [NREG-1:0] w_wr_hit;
    logic [XLEN-1:0] w_wr_val [NREG];

    // Per-read-port next values
    logic [AW-1:0]   w_rd_addr [NRD];
    logic [XLEN-1:0] w_rd_val  [NRD];
    logic [NRD-1:0]  w_rd_busy;

    logic [NREG-1:0] w_busy_d;

    // Resolve write ports per register; ascending scan lets the highest index win
    always_comb begin
        for (int unsigned a = 0; a < NREG; a++) begin
            w_wr_hit[a] = 1'b0;
            w_wr_val[a] = '0;
        end
        // Register 0 is never a write target, so its hit/value stay zero
        for (int unsigned a = 1; a < NREG; a++) begin
            for (int unsigned p = 0; p < NWR; p++) begin
                if (i_wr_en[p] && (i_wr_addr[p*AW +: AW] == AW'(a))) begin
                    w_wr_hit[a] = 1'b1;
                    w_wr_val[a] = i_wr_data[p*XLEN +: XLEN];
                end
            end
        end
    end

    // Read-port next values: zero register, then bypass, then array
    always_comb begin
        for (int unsigned k = 0; k < NRD; k++) begin
            w_rd_addr[k] = i_rd_addr[k*AW +: AW];
            w_rd_val[k]  = '0;
            w_rd_busy[k] = 1'b0;
            if (w_rd_addr[k] != '0) begin
                if (w_wr_hit[w_rd_addr[k]]) begin
                    w_rd_val[k] = w_wr_val[w_rd_addr[k]];
                end else begin
                    w_rd_val[k] = r_regs[w_rd_addr[k]];
                end
                // A same-cycle write produces the operand, so it is no longer pending
                w_rd_busy[k] = r_busy[w_rd_addr[k]] & ~w_wr_hit[w_rd_addr[k]];
            end
        end
    end

    // Scoreboard next state: writes clear, issue sets (set beats clear), flush clears all
    always_comb begin
        w_busy_d = r_busy & ~w_wr_hit;
        if (i_iss_valid && (i_iss_rd != '0)) begin
            w_busy_d[i_iss_rd] = 1'b1;
        end
        if (i_flush) begin
            w_busy_d = '0;
        end
        w_busy_d[0] = 1'b0;
    end

    // Register array update; reset loads SP_INIT into the stack pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned a = 0; a < NREG; a++) begin
                r_regs[a] <= ((a == SP_IDX) && (a != 0)) ? SP_INIT : '0;
            end
        end else begin
            for (int unsigned a = 1; a < NREG; a++) begin
                if (w_wr_hit[a]) begin
                    r_regs[a] <= w_wr_val[a];
                end
            end
        end
    end

    // Busy scoreboard register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_d;
        end
    end

    // Read output registers; hold while decode is stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NRD; k++) begin
                r_rd_data[k] <= '0;
            end
            r_rd_busy <= '0;
        end else if (i_rd_en) begin
            for (int unsigned k = 0; k < NRD; k++) begin
                r_rd_data[k] <= w_rd_val[k];
            end
            r_rd_busy <= w_rd_busy;
        end
    end

    // Pack read data onto the flat output bus
    always_comb begin
        o_rd_data = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            o_rd_data[k*XLEN +: XLEN] = r_rd_data[k];
        end
    end

    assign o_rd_busy = r_rd_busy;

endmodule

// File: tb/tb_rip_regfile_mp.sv
// Directed testbench for rip_regfile_mp (default 32x32, 2R/2W, SP at x2).
module tb_rip_regfile_mp;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam logic [31:0] SPV  = 32'h0000_1000;

    logic              clk;
    logic              rst_n;
    logic              i_rd_en;
    logic [2*AW-1:0]   i_rd_addr;
    logic [2*XLEN-1:0] o_rd_data;
    logic [1:0]        o_rd_busy;
    logic [1:0]        i_wr_en;
    logic [2*AW-1:0]   i_wr_addr;
    logic [2*XLEN-1:0] i_wr_data;
    logic              i_iss_valid;
    logic [AW-1:0]     i_iss_rd;
    logic              i_flush;

    int tests_run;
    int tests_failed;

    rip_regfile_mp #(
        .XLEN    (XLEN),
        .NREG    (NREG),
        .NRD     (2),
        .NWR     (2),
        .SP_IDX  (2),
        .SP_INIT (SPV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rd_en     (i_rd_en),
        .i_rd_addr   (i_rd_addr),
        .o_rd_data   (o_rd_data),
        .o_rd_busy   (o_rd_busy),
        .i_wr_en     (i_wr_en),
        .i_wr_addr   (i_wr_addr),
        .i_wr_data   (i_wr_data),
        .i_iss_valid (i_iss_valid),
        .i_iss_rd    (i_iss_rd),
        .i_flush     (i_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst_n       = 1'b1;
        i_rd_en     = 1'b0;
        i_rd_addr   = '0;
        i_wr_en     = 2'b00;
        i_wr_addr   = '0;
        i_wr_data   = '0;
        i_iss_valid = 1'b0;
        i_iss_rd    = '0;
        i_flush     = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a0);
        i_rd_en   = 1'b1;
        i_rd_addr = {a1, a0};
    endtask

    task automatic test_reset();
        idle();
        rst_n     = 1'b0;
        rd(5'd2, 5'd2);
        i_wr_en   = 2'b01;
        i_wr_addr = {5'd0, 5'd2};
        i_wr_data = {32'h0, 32'hFFFF_FFFF};
        step();
        step();
        tests_run++;
        if (o_rd_data !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h want 0", o_rd_data);
        end
        tests_run++;
        if (o_rd_busy !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_busy: got %b want 00", o_rd_busy);
        end
        idle();
        rd(5'd5, 5'd2);
        step();
        tests_run++;
        if (o_rd_data[31:0] !== SPV) begin
            tests_failed++;
            $display("FAIL reset_sp: got %h want %h", o_rd_data[31:0], SPV);
        end
        tests_run++;
        if (o_rd_data[63:32] !== 32'h0 || o_rd_busy !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_x5: got %h/%b want 0/00", o_rd_data[63:32], o_rd_busy);
        end
    endtask

    task automatic test_bypass();
        idle();
        rd(5'd0, 5'd7);
        i_wr_en   = 2'b11;
        i_wr_addr = {5'd7, 5'd7};
        i_wr_data = {32'hBBBB_0002, 32'hAAAA_0001};
        step();
        tests_run++;
        if (o_rd_data[31:0] !== 32'hBBBB_0002) begin
            tests_failed++;
            $display("FAIL bypass_prio: got %h want BBBB0002", o_rd_data[31:0]);
        end
        idle();
        rd(5'd7, 5'd7);
        step();
        tests_run++;
        if (o_rd_data !== {32'hBBBB_0002, 32'hBBBB_0002}) begin
            tests_failed++;
            $display("FAIL array_prio: got %h want BBBB0002 x2", o_rd_data);
        end
        // Two distinct writes, each bypassed to its own read port
        idle();
        rd(5'd11, 5'd10);
        i_wr_en   = 2'b11;
        i_wr_addr = {5'd11, 5'd10};
        i_wr_data = {32'h0000_0011, 32'h0000_0010};
        step();
        tests_run++;
        if (o_rd_data !== {32'h0000_0011, 32'h0000_0010}) begin
            tests_failed++;
            $display("FAIL bypass_dual: got %h want 00000011_00000010", o_rd_data);
        end
        idle();
        rd(5'd10, 5'd11);
        step();
        tests_run++;
        if (o_rd_data !== {32'h0000_0010, 32'h0000_0011}) begin
            tests_failed++;
            $display("FAIL array_dual: got %h want 00000010_00000011", o_rd_data);
        end
    endtask

    task automatic test_zero();
        idle();
        rd(5'd0, 5'd0);
        i_wr_en   = 2'b01;
        i_wr_addr = {5'd0, 5'd0};
        i_wr_data = {32'h0, 32'hDEAD_BEEF};
        step();
        tests_run++;
        if (o_rd_data[31:0] !== 32'h0) begin
            tests_failed++;
            $display("FAIL zero_bypass: got %h want 0", o_rd_data[31:0]);
        end
        idle();
        rd(5'd0, 5'd0);
        i_iss_valid = 1'b1;
        i_iss_rd    = 5'd0;
        step();
        tests_run++;
        if (o_rd_data[31:0] !== 32'h0) begin
            tests_failed++;
            $display("FAIL zero_read: got %h want 0", o_rd_data[31:0]);
        end
        idle();
        rd(5'd0, 5'd0);
        step();
        tests_run++;
        if (o_rd_busy !== 2'b00) begin
            tests_failed++;
            $display("FAIL zero_busy: got %b want 00", o_rd_busy);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        i_iss_valid = 1'b1;
        i_iss_rd    = 5'd9;
        rd(5'd9, 5'd1);
        step();
        // Issue in the same cycle as the read does not mark it busy yet
        tests_run++;
        if (o_rd_busy !== 2'b00) begin
            tests_failed++;
            $display("FAIL issue_same_cycle: got %b want 00", o_rd_busy);
        end
        idle();
        rd(5'd1, 5'd9);
        step();
        tests_run++;
        if (o_rd_busy !== 2'b01) begin
            tests_failed++;
            $display("FAIL busy_set: got %b want 01", o_rd_busy);
        end
        idle();
        rd(5'd9, 5'd9);
        i_wr_en   = 2'b10;
        i_wr_addr = {5'd9, 5'd0};
        i_wr_data = {32'h0000_1234, 32'h0};
        step();
        tests_run++;
        if (o_rd_data !== {32'h0000_1234, 32'h0000_1234} || o_rd_busy !== 2'b00) begin
            tests_failed++;
            $display("FAIL busy_bypass: got %h/%b want 1234 x2/00", o_rd_data, o_rd_busy);
        end
        idle();
        rd(5'd0, 5'd9);
        step();
        tests_run++;
        if (o_rd_busy !== 2'b00 || o_rd_data[31:0] !== 32'h0000_1234) begin
            tests_failed++;
            $display("FAIL busy_clear: got %h/%b want 1234/00", o_rd_data[31:0], o_rd_busy);
        end
    endtask

    task automatic test_set_wins_flush();
        idle();
        i_iss_valid = 1'b1;
        i_iss_rd    = 5'd4;
        i_wr_en     = 2'b01;
        i_wr_addr   = {5'd0, 5'd4};
        i_wr_data   = {32'h0, 32'h0000_0044};
        step();
        idle();
        rd(5'd0, 5'd4);
        step();
        tests_run++;
        if (o_rd_busy !== 2'b01 || o_rd_data[31:0] !== 32'h0000_0044) begin
            tests_failed++;
            $display("FAIL set_wins: got %h/%b want 44/01", o_rd_data[31:0], o_rd_busy);
        end
        // Flush overrides a same-cycle issue to the same register
        idle();
        i_flush     = 1'b1;
        i_iss_valid = 1'b1;
        i_iss_rd    = 5'd4;
        step();
        idle();
        rd(5'd0, 5'd4);
        step();
        tests_run++;
        if (o_rd_busy !== 2'b00) begin
            tests_failed++;
            $display("FAIL flush: got %b want 00", o_rd_busy);
        end
    endtask

    task automatic test_hold_and_reset();
        idle();
        i_wr_en   = 2'b01;
        i_wr_addr = {5'd0, 5'd3};
        i_wr_data = {32'h0, 32'h0000_0055};
        step();
        idle();
        rd(5'd0, 5'd3);
        step();
        tests_run++;
        if (o_rd_data[31:0] !== 32'h0000_0055) begin
            tests_failed++;
            $display("FAIL hold_pre: got %h want 55", o_rd_data[31:0]);
        end
        idle();
        i_rd_addr   = {5'd2, 5'd2};
        i_wr_en     = 2'b01;
        i_wr_addr   = {5'd0, 5'd3};
        i_wr_data   = {32'h0, 32'h0000_0066};
        i_iss_valid = 1'b1;
        i_iss_rd    = 5'd20;
        step();
        tests_run++;
        if (o_rd_data !== {32'h0, 32'h0000_0055} || o_rd_busy !== 2'b00) begin
            tests_failed++;
            $display("FAIL hold: got %h/%b want 0_55/00", o_rd_data, o_rd_busy);
        end
        idle();
        rd(5'd20, 5'd3);
        step();
        tests_run++;
        if (o_rd_data[31:0] !== 32'h0000_0066 || o_rd_busy !== 2'b10) begin
            tests_failed++;
            $display("FAIL hold_release: got %h/%b want 66/10", o_rd_data[31:0], o_rd_busy);
        end
        // Reset mid-sequence, with a write and an issue pending in the same cycle
        idle();
        rst_n       = 1'b0;
        rd(5'd20, 5'd3);
        i_wr_en     = 2'b01;
        i_wr_addr   = {5'd0, 5'd3};
        i_wr_data   = {32'h0, 32'h0000_0077};
        i_iss_valid = 1'b1;
        i_iss_rd    = 5'd21;
        step();
        tests_run++;
        if (o_rd_data !== 64'h0 || o_rd_busy !== 2'b00) begin
            tests_failed++;
            $display("FAIL mid_reset: got %h/%b want 0/00", o_rd_data, o_rd_busy);
        end
        idle();
        rd(5'd3, 5'd2);
        step();
        tests_run++;
        if (o_rd_data !== {32'h0, SPV}) begin
            tests_failed++;
            $display("FAIL post_reset_data: got %h want 0_%h", o_rd_data, SPV);
        end
        idle();
        rd(5'd21, 5'd20);
        step();
        tests_run++;
        if (o_rd_busy !== 2'b00) begin
            tests_failed++;
            $display("FAIL post_reset_busy: got %b want 00", o_rd_busy);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        idle();
        test_reset();
        test_bypass();
        test_zero();
        test_scoreboard();
        test_set_wins_flush();
        test_hold_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
